// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - frame controller feeding a serial 1011 Moore detector
//
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   s_valid  input word valid
//   s_ready  input word ready
//   s_data   input word, shifted onto det_in MSB first
//   s_last   input word is the last of its frame
//   r_valid  frame result valid (held until r_ready)
//   r_ready  frame result accepted
//   r_count  saturating hit count for the frame
//   r_err    frame was aborted by an input underrun
//   det_in   serial bit to the detector
//   det_rst  registered active-low clear to the detector
//   det_out  detector Moore output (reflects bits up to the previous cycle)
//   busy     controller is not idle
module seq_det_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [CNT_W-1:0] r_count,
  output logic             r_err,
  output logic             det_in,
  output logic             det_rst,
  input  logic             det_out,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    DRAIN,
    REPORT,
    FLUSH
  } state_t;

  state_t state;
  state_t state_next;

  // Serialiser: word being shifted out, its last flag and bit position
  logic [WIDTH-1:0] sh;
  logic             cur_last;
  logic [IDX_W-1:0] bit_idx;

  // One-entry next-word buffer
  logic [WIDTH-1:0] nb_data;
  logic             nb_last;
  logic             nb_valid;

  // Per-frame result state
  logic [CNT_W-1:0] cnt;
  logic             primed;
  logic             err;

  // Combinational controls
  logic s_fire;
  logic nb_write;
  logic nb_clear;
  logic load_sh;
  logic start_frame;
  logic hit_en;
  logic set_err;
  logic det_rst_next;

  always_comb begin
    state_next   = state;
    s_ready      = 1'b0;
    r_valid      = 1'b0;
    nb_clear     = 1'b0;
    load_sh      = 1'b0;
    start_frame  = 1'b0;
    hit_en       = 1'b0;
    set_err      = 1'b0;

    case (state)
      IDLE: begin
        s_ready = !nb_valid;
        if (nb_valid) begin
          load_sh     = 1'b1;
          start_frame = 1'b1;
          nb_clear    = 1'b1;
          state_next  = SHIFT;
        end
      end

      SHIFT: begin
        s_ready = !nb_valid;
        // The first SHIFT cycle of a frame still sees the cleared detector.
        hit_en  = primed;
        if (bit_idx == LAST_IDX) begin
          if (cur_last) begin
            state_next = DRAIN;
          end else if (nb_valid) begin
            // Chain the next word with no bubble so matches span the boundary.
            load_sh  = 1'b1;
            nb_clear = 1'b1;
          end else begin
            set_err    = 1'b1;
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        // det_out now reflects the final bit of the frame.
        hit_en     = 1'b1;
        state_next = REPORT;
      end

      REPORT: begin
        r_valid = 1'b1;
        if (r_ready) begin
          state_next = err ? FLUSH : IDLE;
        end
      end

      FLUSH: begin
        // Anything buffered or arriving belongs to the aborted frame.
        s_ready  = 1'b1;
        nb_clear = 1'b1;
        if ((nb_valid && nb_last) || (s_valid && s_last)) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    s_fire       = s_valid && s_ready;
    nb_write     = s_fire && (state != FLUSH);
    det_rst_next = (state_next == SHIFT) || (state_next == DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      det_rst  <= 1'b0;
      sh       <= '0;
      cur_last <= 1'b0;
      bit_idx  <= '0;
      nb_data  <= '0;
      nb_last  <= 1'b0;
      nb_valid <= 1'b0;
      cnt      <= '0;
      primed   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= state_next;
      det_rst <= det_rst_next;

      // nb_write only happens with nb empty and nb_clear only with nb full
      // (or in FLUSH, where nothing is written), so the two never collide.
      if (nb_write) begin
        nb_valid <= 1'b1;
        nb_data  <= s_data;
        nb_last  <= s_last;
      end else if (nb_clear) begin
        nb_valid <= 1'b0;
      end

      if (load_sh) begin
        sh       <= nb_data;
        cur_last <= nb_last;
        bit_idx  <= '0;
      end else if (state == SHIFT) begin
        sh      <= sh << 1;
        bit_idx <= bit_idx + 1'b1;
      end

      if (start_frame) begin
        cnt    <= '0;
        err    <= 1'b0;
        primed <= 1'b0;
      end else begin
        if (state == SHIFT) begin
          primed <= 1'b1;
        end
        if (hit_en && det_out && (cnt != CNT_MAX)) begin
          cnt <= cnt + 1'b1;
        end
        if (set_err) begin
          err <= 1'b1;
        end
      end
    end
  end

  assign det_in  = (state == SHIFT) ? sh[WIDTH-1] : 1'b0;
  assign r_count = cnt;
  assign r_err   = err;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - directed self-checking bench for seq_det_ctrl
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       r_ready = 1'b1;

  logic       s_ready8, r_valid8, r_err8, det_in8, det_rst8, det_out8, busy8;
  logic [7:0] r_count8;
  logic       s_ready2, r_valid2, r_err2, det_in2, det_rst2, det_out2, busy2;
  logic [1:0] r_count2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hi_total = 0;
  int rise_total = 0;
  int last_rise = -1;
  logic drst_prev = 1'b0;

  logic [2:0] ds8 = 3'd0;
  logic [2:0] ds2 = 3'd0;

  seq_det_ctrl #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst_n),
    .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data), .s_last(s_last),
    .r_valid(r_valid8), .r_ready(r_ready), .r_count(r_count8), .r_err(r_err8),
    .det_in(det_in8), .det_rst(det_rst8), .det_out(det_out8), .busy(busy8)
  );

  seq_det_ctrl #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst_n),
    .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
    .r_valid(r_valid2), .r_ready(r_ready), .r_count(r_count2), .r_err(r_err2),
    .det_in(det_in2), .det_rst(det_rst2), .det_out(det_out2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Overlapping 1011 Moore detector: 0=none 1="1" 2="10" 3="101" 4="1011"
  function automatic logic [2:0] dnext(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd1 : 3'd2;
      3'd2:    return b ? 3'd3 : 3'd0;
      3'd3:    return b ? 3'd4 : 3'd2;
      default: return b ? 3'd1 : 3'd2;
    endcase
  endfunction

  always @(posedge clk) ds8 <= !det_rst8 ? 3'd0 : dnext(ds8, det_in8);
  always @(posedge clk) ds2 <= !det_rst2 ? 3'd0 : dnext(ds2, det_in2);
  assign det_out8 = (ds8 == 3'd4);
  assign det_out2 = (ds2 == 3'd4);

  // det_rst activity record, sampled just after each falling edge
  always begin
    @(negedge clk);
    #1;
    if (det_rst8 && !drst_prev) begin
      rise_total = rise_total + 1;
      last_rise  = cyc;
    end
    if (det_rst8) hi_total = hi_total + 1;
    drst_prev = det_rst8;
  end

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_word(input string name, input logic [7:0] d, input logic l, output int t);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    total++;
    if (!s_ready8) begin
      bad++;
      $display("FAIL %s send_timeout got_ready=%b exp_ready=1", name, s_ready8);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic get_result(input string name, input int ec8, input int ec2,
                            input logic ee, output int rcyc);
    int n;
    logic [1:0] e2;
    n = 0;
    e2 = ec2[1:0];
    while (!r_valid8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    rcyc = cyc;
    total++;
    if (r_valid8 !== 1'b1 || r_valid2 !== 1'b1) begin
      bad++;
      $display("FAIL %s result_timeout got=%b%b exp=11", name, r_valid8, r_valid2);
    end else begin
      total++;
      if (r_count8 !== ec8[7:0]) begin
        bad++;
        $display("FAIL %s count8 got=%0d exp=%0d", name, r_count8, ec8);
      end
      total++;
      if (r_count2 !== e2) begin
        bad++;
        $display("FAIL %s count2 got=%0d exp=%0d", name, r_count2, e2);
      end
      total++;
      if (r_err8 !== ee || r_err2 !== ee) begin
        bad++;
        $display("FAIL %s err got=%b%b exp=%b", name, r_err8, r_err2, ee);
      end
    end
    r_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({s_ready8, r_valid8, r_count8, r_err8, det_rst8, det_in8, busy8} !==
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outs8 got=%b exp=%b",
               {s_ready8, r_valid8, r_count8, r_err8, det_rst8, det_in8, busy8}, 14'b10000000000000);
    end
    total++;
    if ({s_ready2, r_valid2, r_count2, r_err2, det_rst2, det_in2, busy2} !==
        {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outs2 got=%b exp=%b",
               {s_ready2, r_valid2, r_count2, r_err2, det_rst2, det_in2, busy2}, 8'b10000000);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int t, r, h0, q0;
    h0 = hi_total;
    q0 = rise_total;
    send_word("single", 8'hB6, 1'b1, t);
    get_result("single", 2, 2, 1'b0, r);
    total++;
    if (r !== t + 11) begin
      bad++;
      $display("FAIL single_latency got=%0d exp=%0d", r - t, 11);
    end
    total++;
    if (last_rise !== t + 2) begin
      bad++;
      $display("FAIL single_detrst_start got=%0d exp=%0d", last_rise - t, 2);
    end
    total++;
    if (hi_total - h0 !== 9 || rise_total - q0 !== 1) begin
      bad++;
      $display("FAIL single_detrst_window got_hi=%0d got_rises=%0d exp_hi=9 exp_rises=1",
               hi_total - h0, rise_total - q0);
    end
  endtask

  task automatic test_contig();
    int t, t2, r, h0, q0;
    h0 = hi_total;
    q0 = rise_total;
    send_word("contig_w0", 8'h05, 1'b0, t);
    send_word("contig_w1", 8'h80, 1'b1, t2);
    total++;
    if (t2 !== t + 2) begin
      bad++;
      $display("FAIL contig_accept got=%0d exp=%0d", t2 - t, 2);
    end
    get_result("contig", 1, 1, 1'b0, r);
    total++;
    if (r !== t + 19) begin
      bad++;
      $display("FAIL contig_latency got=%0d exp=%0d", r - t, 19);
    end
    total++;
    if (hi_total - h0 !== 17 || rise_total - q0 !== 1) begin
      bad++;
      $display("FAIL contig_detrst got_hi=%0d got_rises=%0d exp_hi=17 exp_rises=1",
               hi_total - h0, rise_total - q0);
    end
  endtask

  task automatic test_back_to_back();
    int t, t2, r1, r2, h0, q0;
    h0 = hi_total;
    q0 = rise_total;
    send_word("b2b_w0", 8'h05, 1'b1, t);
    send_word("b2b_w1", 8'h80, 1'b1, t2);
    get_result("b2b_f0", 0, 0, 1'b0, r1);
    get_result("b2b_f1", 0, 0, 1'b0, r2);
    total++;
    if (r1 !== t + 11 || r2 !== r1 + 11) begin
      bad++;
      $display("FAIL b2b_latency got=%0d,%0d exp=11,11", r1 - t, r2 - r1);
    end
    total++;
    if (hi_total - h0 !== 18 || rise_total - q0 !== 2) begin
      bad++;
      $display("FAIL b2b_detrst got_hi=%0d got_rises=%0d exp_hi=18 exp_rises=2",
               hi_total - h0, rise_total - q0);
    end
  endtask

  task automatic test_underrun();
    int t, r, seen;
    send_word("under_ff", 8'hFF, 1'b0, t);
    get_result("under", 0, 0, 1'b1, r);
    total++;
    if (r !== t + 11) begin
      bad++;
      $display("FAIL under_latency got=%0d exp=%0d", r - t, 11);
    end
    send_word("flush_w0", 8'h0B, 1'b0, t);
    send_word("flush_w1", 8'h0B, 1'b1, t);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (r_valid8 || busy8) seen++;
      @(negedge clk);
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL flush_drop got_active_cycles=%0d exp=0", seen);
    end
    send_word("after_flush", 8'h58, 1'b1, t);
    get_result("after_flush", 1, 1, 1'b0, r);
    total++;
    if (r !== t + 11) begin
      bad++;
      $display("FAIL after_flush_latency got=%0d exp=%0d", r - t, 11);
    end
  endtask

  task automatic test_saturate();
    int t, r;
    send_word("sat_w0", 8'hB6, 1'b0, t);
    send_word("sat_w1", 8'hDB, 1'b1, t);
    get_result("sat", 5, 3, 1'b0, r);
  endtask

  task automatic test_backpressure();
    int t, n, badcyc;
    r_ready = 1'b0;
    send_word("bp", 8'hB6, 1'b1, t);
    n = 0;
    while (!r_valid8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    badcyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (r_valid8 !== 1'b1 || r_count8 !== 8'd2 || s_ready8 !== 1'b0 || r_err8 !== 1'b0) badcyc++;
      @(negedge clk);
    end
    total++;
    if (badcyc !== 0) begin
      bad++;
      $display("FAIL bp_hold got_bad_cycles=%0d exp=0 (last valid=%b count=%0d ready=%b)",
               badcyc, r_valid8, r_count8, s_ready8);
    end
    r_ready = 1'b1;
    @(negedge clk);
    total++;
    if (r_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got_valid=%b got_busy=%b exp=0 0", r_valid8, busy8);
    end
  endtask

  task automatic test_reset_mid();
    int t, r, seen;
    send_word("rmid", 8'hB6, 1'b1, t);
    repeat (3) @(negedge clk);
    total++;
    if (busy8 !== 1'b1 || det_rst8 !== 1'b1) begin
      bad++;
      $display("FAIL rmid_shifting got_busy=%b got_detrst=%b exp=1 1", busy8, det_rst8);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready8, r_valid8, r_count8, r_err8, det_rst8, det_in8, busy8} !==
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rmid_outs8 got=%b exp=%b",
               {s_ready8, r_valid8, r_count8, r_err8, det_rst8, det_in8, busy8}, 14'b10000000000000);
    end
    total++;
    if ({s_ready2, r_valid2, det_rst2, busy2} !== 4'b1000) begin
      bad++;
      $display("FAIL rmid_outs2 got=%b exp=1000", {s_ready2, r_valid2, det_rst2, busy2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (r_valid8 || busy8) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rmid_no_result got_active_cycles=%0d exp=0", seen);
    end
    send_word("rmid_next", 8'hB6, 1'b1, t);
    get_result("rmid_next", 2, 2, 1'b0, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_contig();
    test_back_to_back();
    test_underrun();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
